iiitb_rtc_disp: RTL and testbench

Six-digit multiplexed seven-segment display driver that consumes the six BCD time digits (hrm, hrl, minm, minl, secm, secl) produced by the RTC core and scans them onto a common-segment display. It samples all six digits once per scan frame to prevent tearing, drives one digit at a time with anti-ghosting blanking, and lights colon dots on alternate seconds. It sits directly downstream of the RTC core and upstream of the io_out pads.

---
 rtl/iiitb_rtc_disp.sv | 126 ++++++++++++
 tb/tb_iiitb_rtc_disp.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/iiitb_rtc_disp.sv
// Six-digit multiplexed seven-segment driver for the RTC time digits.
// Digits are snapshotted once per scan frame so a frame never mixes two times.
module iiitb_rtc_disp #(
    parameter int unsigned REFRESH_DIV  = 1000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter bit          LZ_BLANK     = 1'b1
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic [3:0] hrm,
    input  logic [3:0] hrl,
    input  logic [3:0] minm,
    input  logic [3:0] minl,
    input  logic [3:0] secm,
    input  logic [3:0] secl,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an
);

    localparam logic [15:0] PreLast    = 16'(REFRESH_DIV - 1);
    localparam logic [15:0] BlankStart = 16'(BLANK_CYCLES);

    logic [15:0]     pre_q, pre_d;
    logic [2:0]      idx_q, idx_d;
    logic [5:0][3:0] snap_q, snap_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic [5:0]      an_q, an_d;

    logic       tick;
    logic       load;
    logic       enable;
    logic [3:0] cur;

    // Anti-ghosting window: digit enables stay off for the first BLANK_CYCLES of each slot.
    if (BLANK_CYCLES == 0) begin : g_no_blank
        assign enable = 1'b1;
    end else begin : g_blank
        assign enable = (pre_q >= BlankStart);
    end

    // Prescaler, digit index and once-per-frame snapshot.
    always_comb begin
        tick  = (pre_q == PreLast);
        load  = (pre_q == 16'd0) && (idx_q == 3'd0);
        pre_d = tick ? 16'd0 : pre_q + 16'd1;
        idx_d = idx_q;
        if (tick) begin
            // 6 and 7 are unreachable but still recover to slot 0.
            idx_d = (idx_q >= 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
        snap_d = snap_q;
        if (load) begin
            snap_d[0] = hrm;
            snap_d[1] = hrl;
            snap_d[2] = minm;
            snap_d[3] = minl;
            snap_d[4] = secm;
            snap_d[5] = secl;
        end
    end

    // Output decode from the currently held index, prescaler and snapshot.
    always_comb begin
        case (idx_q)
            3'd0:    cur = snap_q[0];
            3'd1:    cur = snap_q[1];
            3'd2:    cur = snap_q[2];
            3'd3:    cur = snap_q[3];
            3'd4:    cur = snap_q[4];
            3'd5:    cur = snap_q[5];
            default: cur = 4'd0;
        endcase

        case (cur)
            4'd0:    seg_d = 7'h3F;
            4'd1:    seg_d = 7'h06;
            4'd2:    seg_d = 7'h5B;
            4'd3:    seg_d = 7'h4F;
            4'd4:    seg_d = 7'h66;
            4'd5:    seg_d = 7'h6D;
            4'd6:    seg_d = 7'h7D;
            4'd7:    seg_d = 7'h07;
            4'd8:    seg_d = 7'h7F;
            4'd9:    seg_d = 7'h6F;
            default: seg_d = 7'h40;
        endcase

        an_d = 6'd0;
        if (enable && (idx_q <= 3'd5)) begin
            an_d = 6'd1 << idx_q;
        end
        // Leading-zero blanking only gates the enable; seg still carries the decode.
        if (LZ_BLANK && (snap_q[0] == 4'd0)) begin
            an_d[0] = 1'b0;
        end

        // Colon dots after hours and minutes, lit on even seconds.
        dp_d = enable && ((idx_q == 3'd1) || (idx_q == 3'd3)) && !snap_q[5][0];
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clkin) begin
        if (!rst) begin
            pre_q  <= 16'd0;
            idx_q  <= 3'd0;
            snap_q <= '0;
            seg_q  <= 7'd0;
            dp_q   <= 1'b0;
            an_q   <= 6'd0;
        end else begin
            pre_q  <= pre_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            an_q   <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_iiitb_rtc_disp.sv
// Bench for iiitb_rtc_disp: two parameterisations driven with shared inputs and
// compared every cycle against a frame/slot arithmetic model of the display.
module tb_iiitb_rtc_disp;

    localparam int RdA = 4;
    localparam int BcA = 1;
    localparam int LzA = 0;
    localparam int RdB = 5;
    localparam int BcB = 0;
    localparam int LzB = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] dig [6];
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;
    logic [5:0] an_a, an_b;

    int n_checks = 0;
    int n_errors = 0;

    // Model state per instance: edges since reset release and the held digits.
    int         cnt   [2];
    logic [3:0] msnap [2][6];
    logic [6:0] want_seg [2];
    logic       want_dp  [2];
    logic [5:0] want_an  [2];

    always #5 clk = ~clk;

    iiitb_rtc_disp #(
        .REFRESH_DIV (RdA),
        .BLANK_CYCLES(BcA),
        .LZ_BLANK    (1'b0)
    ) u_dut_a (
        .clkin(clk),
        .rst  (rst),
        .hrm  (dig[0]),
        .hrl  (dig[1]),
        .minm (dig[2]),
        .minl (dig[3]),
        .secm (dig[4]),
        .secl (dig[5]),
        .seg  (seg_a),
        .dp   (dp_a),
        .an   (an_a)
    );

    iiitb_rtc_disp #(
        .REFRESH_DIV (RdB),
        .BLANK_CYCLES(BcB),
        .LZ_BLANK    (1'b1)
    ) u_dut_b (
        .clkin(clk),
        .rst  (rst),
        .hrm  (dig[0]),
        .hrl  (dig[1]),
        .minm (dig[2]),
        .minl (dig[3]),
        .secm (dig[4]),
        .secl (dig[5]),
        .seg  (seg_b),
        .dp   (dp_b),
        .an   (an_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        if (obs !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, want, $time);
        end
    endtask

    function automatic logic [6:0] seven_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // Predict what instance k shows after the coming edge.
    task automatic model_edge(input int k);
        int rd, bc, lz, pre, idx;
        bit en;
        rd = (k == 0) ? RdA : RdB;
        bc = (k == 0) ? BcA : BcB;
        lz = (k == 0) ? LzA : LzB;
        if (!rst) begin
            want_seg[k] = 7'd0;
            want_dp[k]  = 1'b0;
            want_an[k]  = 6'd0;
            cnt[k]      = 0;
            for (int i = 0; i < 6; i++) msnap[k][i] = 4'd0;
        end else begin
            pre = cnt[k] % rd;
            idx = (cnt[k] / rd) % 6;
            en  = (pre >= bc);
            want_seg[k] = seven_seg(msnap[k][idx]);
            want_an[k]  = en ? 6'(1 << idx) : 6'd0;
            if (lz != 0 && idx == 0 && msnap[k][0] == 4'd0) want_an[k] = 6'd0;
            want_dp[k] = en && (idx == 1 || idx == 3) && (msnap[k][5][0] == 1'b0);
            if (cnt[k] % (6 * rd) == 0) begin
                for (int i = 0; i < 6; i++) msnap[k][i] = dig[i];
            end
            cnt[k]++;
        end
    endtask

    task automatic step();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        check("a_seg", 32'(seg_a), 32'(want_seg[0]));
        check("a_an",  32'(an_a),  32'(want_an[0]));
        check("a_dp",  32'(dp_a),  32'(want_dp[0]));
        check("b_seg", 32'(seg_b), 32'(want_seg[1]));
        check("b_an",  32'(an_b),  32'(want_an[1]));
        check("b_dp",  32'(dp_b),  32'(want_dp[1]));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int first_an;
        int guard;
        logic [5:0] first_val;

        // Reset held with arbitrary digits.
        for (int i = 0; i < 6; i++) dig[i] = 4'($urandom_range(0, 15));
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rst_seg", 32'(seg_a), 32'd0);
            check("rst_an",  32'(an_a | an_b), 32'd0);
        end

        // Scan order with digits 1..6; first enable lands BLANK_CYCLES+1 edges after release.
        for (int i = 0; i < 6; i++) dig[i] = 4'(i + 1);
        rst = 1'b1;
        first_an  = -1;
        first_val = 6'd0;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (first_an < 0 && an_a != 6'd0) begin
                first_an  = e;
                first_val = an_a;
            end
        end
        check("first_an_edge", 32'(first_an), 32'(BcA + 1));
        check("first_an_val", 32'(first_val), 32'h1);
        run(40);

        // Mid-frame change of minl: held digits stay until the next frame load.
        dig[3] = 4'd4;
        run(30);
        dig[3] = 4'd7;
        run(50);

        // Leading zero and colon behaviour.
        dig[0] = 4'd0;
        dig[5] = 4'd8;
        run(70);
        dig[5] = 4'd9;
        run(70);

        // Invalid BCD shows a dash.
        dig[1] = 4'hC;
        run(40);

        // Reset asserted during slot 4 of instance A.
        guard = 0;
        while (((cnt[0] / RdA) % 6) != 4 && guard < 40) begin
            step();
            guard++;
        end
        check("reach_slot4", 32'(guard < 40), 32'd1);
        rst = 1'b0;
        step();
        check("midrst_an", 32'(an_a), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) dig[i] = 4'($urandom_range(0, 9));
        run(60);

        // Random digits with occasional resets.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 7) == 0) dig[$urandom_range(0, 5)] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) dig[0] = 4'($urandom_range(0, 2));
            rst = ($urandom_range(0, 79) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
